de_hazard_ctrl: RTL and testbench

Issue controller for the decode stage of the 5-stage RISC-V pipeline. It holds a per-register scoreboard of in-flight register writes and decides each cycle whether the instruction in DE may advance into the DE latch. It runs a small branch state machine that freezes fetch from the moment a control-transfer instruction sits in DE until AGEX resolves it. It drives the DE-stage stall and the DE-to-FE stall.

---
 rtl/de_hazard_ctrl_if.sv | 30 +++
 rtl/de_hazard_ctrl.sv | 78 +++++++
 tb/tb_de_hazard_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/de_hazard_ctrl_if.sv
// de_hazard_ctrl_if: decode-stage issue/hazard signals between the pipeline (master) and the controller (slave).
interface de_hazard_ctrl_if #(parameter int REGNOBITS = 5);
    logic                 de_valid;
    logic [REGNOBITS-1:0] de_rs1;
    logic                 de_rs1_used;
    logic [REGNOBITS-1:0] de_rs2;
    logic                 de_rs2_used;
    logic                 de_wr_reg;
    logic [REGNOBITS-1:0] de_rd;
    logic                 de_is_br;
    logic                 agex_br_resolved;
    logic                 wb_wr_reg;
    logic [REGNOBITS-1:0] wb_rd;
    logic                 issue;
    logic                 stall_de;
    logic                 stall_fe;
    logic                 br_state;
    logic                 sb_err;

    modport master (
        output de_valid, de_rs1, de_rs1_used, de_rs2, de_rs2_used, de_wr_reg, de_rd, de_is_br,
        output agex_br_resolved, wb_wr_reg, wb_rd,
        input  issue, stall_de, stall_fe, br_state, sb_err
    );
    modport slave (
        input  de_valid, de_rs1, de_rs1_used, de_rs2, de_rs2_used, de_wr_reg, de_rd, de_is_br,
        input  agex_br_resolved, wb_wr_reg, wb_rd,
        output issue, stall_de, stall_fe, br_state, sb_err
    );
endinterface

// File: rtl/de_hazard_ctrl.sv
// de_hazard_ctrl: DE-stage scoreboard, issue/stall control and branch fetch freeze.
// Optional WB_BYPASS_EN: sources written by WB this cycle (last in-flight write) are not hazardous.
module de_hazard_ctrl #(
    parameter int REGWORDS    = 32,
    parameter int REGNOBITS   = 5,
    parameter int MAXINFLIGHT = 3,
    parameter int CNTBITS     = 2
) (
    input logic            clk,
    input logic            reset,
    de_hazard_ctrl_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, BR_WAIT = 1'b1} br_t;

    logic [CNTBITS-1:0]  r_cnt [REGWORDS];
    br_t                 r_state;
    br_t                 w_state_nxt;
    logic                r_sb_err;
    logic                w_byp1;
    logic                w_byp2;
    logic                w_haz1;
    logic                w_haz2;
    logic                w_waw;
    logic                w_stall;
    logic                w_issue;
    logic                w_underflow;
    logic [REGWORDS-1:0] w_inc;
    logic [REGWORDS-1:0] w_dec;

    always_comb begin
`ifdef WB_BYPASS_EN
        w_byp1 = bus.wb_wr_reg && bus.wb_rd == bus.de_rs1 && r_cnt[bus.de_rs1] == CNTBITS'(1);
        w_byp2 = bus.wb_wr_reg && bus.wb_rd == bus.de_rs2 && r_cnt[bus.de_rs2] == CNTBITS'(1);
`else
        w_byp1 = 1'b0;
        w_byp2 = 1'b0;
`endif
        w_haz1      = bus.de_rs1_used && bus.de_rs1 != '0 && r_cnt[bus.de_rs1] != '0 && !w_byp1;
        w_haz2      = bus.de_rs2_used && bus.de_rs2 != '0 && r_cnt[bus.de_rs2] != '0 && !w_byp2;
        w_waw       = bus.de_wr_reg && bus.de_rd != '0 && r_cnt[bus.de_rd] == CNTBITS'(MAXINFLIGHT);
        w_stall     = bus.de_valid && (w_haz1 || w_haz2 || w_waw || r_state == BR_WAIT);
        w_issue     = bus.de_valid && !w_stall;
        w_inc       = (w_issue && bus.de_wr_reg && bus.de_rd != '0) ? (REGWORDS'(1) << bus.de_rd) : '0;
        w_dec       = (bus.wb_wr_reg && bus.wb_rd != '0) ? (REGWORDS'(1) << bus.wb_rd) : '0;
        w_underflow = bus.wb_wr_reg && bus.wb_rd != '0 && r_cnt[bus.wb_rd] == '0;
        w_state_nxt = r_state;
        if (r_state == IDLE && w_issue && bus.de_is_br)
            w_state_nxt = BR_WAIT;
        else if (r_state == BR_WAIT && bus.agex_br_resolved)
            w_state_nxt = IDLE;
    end

    assign bus.issue    = w_issue;
    assign bus.stall_de = w_stall;
    assign bus.stall_fe = w_stall || (bus.de_valid && bus.de_is_br && r_state == IDLE);
    assign bus.br_state = r_state == BR_WAIT;
    assign bus.sb_err   = r_sb_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < REGWORDS; r++)
                r_cnt[r] <= '0;
            r_state  <= IDLE;
            r_sb_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_underflow)
                r_sb_err <= 1'b1;
            // Index 0 is never written after reset, so x0 always reads as not in flight.
            for (int r = 1; r < REGWORDS; r++) begin
                if (w_inc[r] && !w_dec[r])
                    r_cnt[r] <= r_cnt[r] + 1'b1;
                else if (w_dec[r] && !w_inc[r] && r_cnt[r] != '0)
                    r_cnt[r] <= r_cnt[r] - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_de_hazard_ctrl.sv
// tb_de_hazard_ctrl: directed stimulus, per-cycle comparison against a scoreboard model, literal spot checks.
module tb_de_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    bit   chk_en = 1'b0;

    int   cnt_m [32];
    bit   brw_m = 1'b0;
    bit   err_m = 1'b0;

    de_hazard_ctrl_if #(.REGNOBITS(5)) bus ();
    de_hazard_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    function automatic bit byp(input int rs);
`ifdef WB_BYPASS_EN
        return bus.wb_wr_reg && int'(bus.wb_rd) == rs && cnt_m[rs] == 1;
`else
        return rs < 0;
`endif
    endfunction

    function automatic bit haz(input int rs, input bit used);
        return used && rs != 0 && cnt_m[rs] != 0 && !byp(rs);
    endfunction

    function automatic bit m_stall();
        return bus.de_valid && (haz(int'(bus.de_rs1), bus.de_rs1_used) || haz(int'(bus.de_rs2), bus.de_rs2_used)
               || (bus.de_wr_reg && bus.de_rd != 0 && cnt_m[bus.de_rd] == 3) || brw_m);
    endfunction

    function automatic bit m_issue();
        return bus.de_valid && !m_stall();
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            foreach (cnt_m[i]) cnt_m[i] = 0;
            brw_m = 1'b0;
            err_m = 1'b0;
        end else begin
            bit iss;
            int rd, wd;
            iss = m_issue();
            rd  = (iss && bus.de_wr_reg && bus.de_rd != 0) ? int'(bus.de_rd) : -1;
            wd  = (bus.wb_wr_reg && bus.wb_rd != 0) ? int'(bus.wb_rd) : -1;
            if (wd >= 0 && cnt_m[wd] == 0) err_m = 1'b1;
            if (rd != wd) begin
                if (rd >= 0) cnt_m[rd]++;
                if (wd >= 0 && cnt_m[wd] > 0) cnt_m[wd]--;
            end
            if (!brw_m && iss && bus.de_is_br) brw_m = 1'b1;
            else if (brw_m && bus.agex_br_resolved) brw_m = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("issue", int'(bus.issue), int'(m_issue()));
            check("stall_de", int'(bus.stall_de), int'(m_stall()));
            check("stall_fe", int'(bus.stall_fe), int'(m_stall() || (bus.de_valid && bus.de_is_br && !brw_m)));
            check("br_state", int'(bus.br_state), int'(brw_m));
            check("sb_err", int'(bus.sb_err), int'(err_m));
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.de_valid = 0; bus.de_rs1 = 0; bus.de_rs1_used = 0; bus.de_rs2 = 0; bus.de_rs2_used = 0;
        bus.de_wr_reg = 0; bus.de_rd = 0; bus.de_is_br = 0;
        bus.agex_br_resolved = 0; bus.wb_wr_reg = 0; bus.wb_rd = 0;
    endtask

    task automatic instr(input int rs1, input bit u1, input int rs2, input bit u2, input bit wr, input int rd, input bit br);
        bus.de_valid = 1; bus.de_rs1 = 5'(rs1); bus.de_rs1_used = u1; bus.de_rs2 = 5'(rs2); bus.de_rs2_used = u2;
        bus.de_wr_reg = wr; bus.de_rd = 5'(rd); bus.de_is_br = br;
    endtask

    task automatic wb(input bit w, input int rd);
        bus.wb_wr_reg = w; bus.wb_rd = 5'(rd);
    endtask

    task automatic lit(input string name, input bit i, input bit sd, input bit sf, input bit bs);
        @(negedge clk);
        check({name, "_issue"}, int'(bus.issue), int'(i));
        check({name, "_stall_de"}, int'(bus.stall_de), int'(sd));
        check({name, "_stall_fe"}, int'(bus.stall_fe), int'(sf));
        check({name, "_br_state"}, int'(bus.br_state), int'(bs));
        nxt();
    endtask

    initial begin
        idle();
        nxt(); nxt();
        reset = 0;
        chk_en = 1'b1;
        lit("idle", 0, 0, 0, 0);
        check("idle_sb_err", int'(bus.sb_err), 0);

        instr(1, 1, 2, 1, 1, 5, 0);
        lit("add_x5", 1, 0, 0, 0);
        instr(5, 1, 2, 1, 1, 6, 0);
        lit("sub_stall", 0, 1, 1, 0);
        wb(1, 5);
`ifdef WB_BYPASS_EN
        lit("sub_wb_cycle", 1, 0, 0, 0);
        idle();
        lit("after_sub", 0, 0, 0, 0);
`else
        lit("sub_wb_cycle", 0, 1, 1, 0);
        wb(0, 0);
        lit("sub_issue", 1, 0, 0, 0);
        idle();
`endif
        wb(1, 6);
        nxt();
        wb(0, 0);

        for (int k = 0; k < 3; k++) begin
            instr(0, 0, 0, 0, 1, 7, 0);
            lit("x7_writer", 1, 0, 0, 0);
        end
        check("model_cnt7_full", cnt_m[7], 3);
        lit("x7_fourth", 0, 1, 1, 0);
        wb(1, 7);
        lit("x7_fourth_wb", 0, 1, 1, 0);
        wb(0, 0);
        lit("x7_fourth_go", 1, 0, 0, 0);
        check("model_cnt7_after", cnt_m[7], 3);
        idle();
        wb(1, 7);
        repeat (3) nxt();
        wb(0, 0);

        instr(1, 1, 2, 1, 0, 0, 1);
        lit("beq", 1, 0, 1, 0);
        instr(3, 1, 4, 1, 1, 8, 0);
        lit("wrong_path", 0, 1, 1, 1);
        bus.agex_br_resolved = 1;
        lit("resolve", 0, 1, 1, 1);
        bus.agex_br_resolved = 0;
        lit("resumed", 1, 0, 0, 0);
        idle();
        wb(1, 8);
        nxt();
        wb(0, 0);
        bus.agex_br_resolved = 1;
        lit("resolve_idle", 0, 0, 0, 0);
        bus.agex_br_resolved = 0;

        instr(0, 0, 0, 0, 1, 9, 0);
        lit("x9_first", 1, 0, 0, 0);
        wb(1, 9);
        lit("x9_inc_dec", 1, 0, 0, 0);
        check("model_cnt9", cnt_m[9], 1);
        idle();
        nxt();
        wb(1, 0);
        lit("wb_x0", 0, 0, 0, 0);
        check("no_err_x0", int'(bus.sb_err), 0);
        wb(1, 3);
        nxt();
        wb(0, 0);
        @(negedge clk);
        check("sb_err_set", int'(bus.sb_err), 1);
        nxt(); nxt();
        check("sb_err_sticky", int'(bus.sb_err), 1);

        instr(0, 0, 0, 0, 1, 5, 0);
        lit("x5_w1", 1, 0, 0, 0);
        lit("x5_w2", 1, 0, 0, 0);
        instr(5, 1, 0, 0, 0, 0, 1);
        lit("br_stalled", 0, 1, 1, 0);
        instr(1, 1, 0, 0, 1, 1, 1);
        lit("jal", 1, 0, 1, 0);
        check("model_cnt5", cnt_m[5], 2);
        idle();
        @(negedge clk);
        check("br_wait_pre_reset", int'(bus.br_state), 1);
        nxt();
        reset = 1;
        nxt();
        reset = 0;
        instr(5, 1, 0, 0, 1, 10, 0);
        lit("post_reset_reader", 1, 0, 0, 0);
        check("post_reset_sb_err", int'(bus.sb_err), 0);
        idle();
        nxt();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
